truth_table_sequencer: RTL and testbench

//  Sequences a 4-input combinational function block (inputs a,b,c,d -> f) through all
//  2**N_IN input combinations in ascending binary order, a = MSB.

---
 rtl/truth_table_sequencer_pkg.sv | 18 +
 rtl/truth_table_sequencer_settle_timer.sv | 36 +++
 rtl/truth_table_sequencer.sv | 143 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared constants for the truth-table sequencer: default geometry, FSM
// state encodings and the settle-counter sizing helper.
package truth_table_sequencer_pkg;

  localparam int TT_N_IN_DEF   = 4;
  localparam int TT_SETTLE_DEF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Counter must reach SETTLE-1; keep at least one bit for SETTLE==1.
  function automatic int tt_cnt_width(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: counts held cycles of one vector and flags the last of
// SETTLE cycles while enabled.
module tt_settle_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int SETTLE = TT_SETTLE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int              CW     = tt_cnt_width(SETTLE);
  localparam logic [CW-1:0]   TC_VAL = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   ONE    = CW'(1);

  logic [CW-1:0] cnt_r;

  // Settle cycle counter; cleared whenever the FSM is outside APPLY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = enable && (cnt_r == TC_VAL);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks all 2**N_IN input vectors, samples f_in after
// a settle delay, assembles the table, counts ones and checks against exp_tt.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN   = TT_N_IN_DEF,
  parameter int SETTLE = TT_SETTLE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   f_in,
  input  logic [(1<<N_IN)-1:0]   exp_tt,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [N_IN:0]          ones_cnt,
  output logic                   mismatch
);

  localparam int                TT_W     = 1 << N_IN;
  localparam logic [N_IN-1:0]   VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]   VEC_ONE  = N_IN'(1);

  logic [1:0]        state_r;
  logic [1:0]        next_state_s;
  logic              settle_tc_s;
  logic [N_IN-1:0]   vec_r;
  logic [TT_W-1:0]   table_r;
  logic [N_IN:0]     ones_r;
  logic              mismatch_r;
  logic              busy_r;
  logic              done_r;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_r != ST_APPLY),
    .enable (state_r == ST_APPLY),
    .tc     (settle_tc_s)
  );

  // Next-state decode; abort only matters while the scan is running.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_APPLY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (settle_tc_s) begin
          next_state_s = ST_SAMPLE;
        end else begin
          next_state_s = ST_APPLY;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (vec_r == VEC_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_APPLY;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, status flags and the scan datapath (vector, table, ones, compare).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      vec_r      <= {N_IN{1'b0}};
      table_r    <= {TT_W{1'b0}};
      ones_r     <= {(N_IN+1){1'b0}};
      mismatch_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_APPLY) || (next_state_s == ST_SAMPLE);
      done_r  <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            vec_r      <= {N_IN{1'b0}};
            table_r    <= {TT_W{1'b0}};
            ones_r     <= {(N_IN+1){1'b0}};
            mismatch_r <= 1'b0;
          end else begin
            vec_r      <= vec_r;
          end
        end
        ST_APPLY, ST_SAMPLE: begin
          if (abort) begin
            vec_r      <= {N_IN{1'b0}};
            table_r    <= {TT_W{1'b0}};
            ones_r     <= {(N_IN+1){1'b0}};
            mismatch_r <= 1'b0;
          end else if (state_r == ST_SAMPLE) begin
            table_r[vec_r] <= f_in;
            ones_r         <= ones_r + {{N_IN{1'b0}}, f_in};
            if (vec_r != VEC_LAST) begin
              vec_r <= vec_r + VEC_ONE;
            end else begin
              // Last bit is still in flight, so splice f_in into the compare.
              mismatch_r <= ({f_in, table_r[TT_W-2:0]} != exp_tt);
            end
          end else begin
            vec_r <= vec_r;
          end
        end
        default: begin
          vec_r <= vec_r;
        end
      endcase
    end
  end

  assign vec_out   = vec_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign table_out = table_r;
  assign ones_cnt  = ones_r;
  assign mismatch  = mismatch_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: default build plus a SETTLE=1 build.
module tb_truth_table_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic [1:0]  sel;
  logic        f_in;
  logic [15:0] exp_tt;
  logic [3:0]  vec_out;
  logic        busy, done, mismatch;
  logic [15:0] table_out;
  logic [4:0]  ones_cnt;

  logic        start1, abort1, f_in1;
  logic [15:0] exp_tt1;
  logic [3:0]  vec_out1;
  logic        busy1, done1, mismatch1;
  logic [15:0] table_out1;
  logic [4:0]  ones_cnt1;

  int checks;
  int failures;

  truth_table_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
    .exp_tt(exp_tt), .vec_out(vec_out), .busy(busy), .done(done),
    .table_out(table_out), .ones_cnt(ones_cnt), .mismatch(mismatch)
  );

  truth_table_sequencer #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f_in1),
    .exp_tt(exp_tt1), .vec_out(vec_out1), .busy(busy1), .done(done1),
    .table_out(table_out1), .ones_cnt(ones_cnt1), .mismatch(mismatch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function block under test: selectable 4-input functions.
  always_comb begin
    case (sel)
      2'd0:    f_in = vec_out[0];
      2'd1:    f_in = ^vec_out;
      2'd2:    f_in = &vec_out;
      default: f_in = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vec(input string tag, input logic [3:0] val, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (vec_out == val) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic run_scan(input string tag, input logic [1:0] s, input logic [15:0] e,
                          input logic with_abort, input logic [15:0] exp_tab,
                          input int exp_ones, input logic exp_mm);
    int   n;
    logic found;
    @(negedge clk);
    sel = s; exp_tt = e; start = 1'b1; abort = with_abort;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    chk({tag, "_done_cycle"}, n + 1, 32'd49);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_table"}, {16'd0, table_out}, {16'd0, exp_tab});
    chk({tag, "_ones"}, {27'd0, ones_cnt}, exp_ones);
    chk({tag, "_mismatch"}, {31'd0, mismatch}, {31'd0, exp_mm});
    chk({tag, "_vec_last"}, {28'd0, vec_out}, 32'd15);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_table_hold"}, {16'd0, table_out}, {16'd0, exp_tab});
  endtask

  initial begin
    int   n;
    logic found;
    logic saw_done;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 2'd0; exp_tt = 16'h0000;
    start1 = 1'b0; abort1 = 1'b0; f_in1 = 1'b1; exp_tt1 = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", {28'd0, vec_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_table", {16'd0, table_out}, 32'd0);
    chk("rst_ones", {27'd0, ones_cnt}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    rst_n = 1'b1;

    // start and abort together in IDLE: start wins.
    run_scan("lsb", 2'd0, 16'hAAAA, 1'b1, 16'hAAAA, 8, 1'b0);

    // abort in IDLE leaves results untouched.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_table", {16'd0, table_out}, 32'h0000AAAA);
    chk("idle_abort_ones", {27'd0, ones_cnt}, 32'd8);
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);

    run_scan("par", 2'd1, 16'h6996, 1'b0, 16'h6996, 8, 1'b0);
    run_scan("and", 2'd2, 16'h0000, 1'b0, 16'h8000, 1, 1'b1);

    // SETTLE=1 build, constant-1 function.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done1) found = 1'b1;
    end
    chk("s1_done_seen", {31'd0, found}, 32'd1);
    chk("s1_done_cycle", n + 1, 32'd33);
    chk("s1_table", {16'd0, table_out1}, 32'h0000FFFF);
    chk("s1_ones", {27'd0, ones_cnt1}, 32'd16);
    chk("s1_mismatch", {31'd0, mismatch1}, 32'd0);

    // abort mid-scan at vec_out==5.
    @(negedge clk);
    sel = 2'd0; exp_tt = 16'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec("abort_reach5", 4'd5, 100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_table", {16'd0, table_out}, 32'd0);
    chk("abort_ones", {27'd0, ones_cnt}, 32'd0);
    chk("abort_vec", {28'd0, vec_out}, 32'd0);
    chk("abort_mismatch", {31'd0, mismatch}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);

    run_scan("after_abort", 2'd0, 16'hAAAA, 1'b0, 16'hAAAA, 8, 1'b0);

    // start pulse mid-scan is ignored; reset mid-scan clears everything.
    @(negedge clk);
    sel = 2'd0; exp_tt = 16'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_vec("mid_reach3", 4'd3, 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_start_busy", {31'd0, busy}, 32'd1);
    chk("mid_start_no_restart", {31'd0, (vec_out >= 4'd3)}, 32'd1);
    wait_vec("mid_reach9", 4'd9, 100);
    rst_n = 1'b0;
    #1;
    chk("mrst_vec", {28'd0, vec_out}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_table", {16'd0, table_out}, 32'd0);
    chk("mrst_ones", {27'd0, ones_cnt}, 32'd0);
    chk("mrst_s1_table", {16'd0, table_out1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_idle_busy", {31'd0, busy}, 32'd0);
    chk("mrst_idle_vec", {28'd0, vec_out}, 32'd0);
    chk("mrst_idle_done", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
